// File: rtl/reset_seq_pkg.sv
// Shared types for the master reset request sequencer.
// State encoding is exported on o_state, so values are fixed.
package reset_seq_pkg;

    localparam int SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_ASSERT    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3
    } seq_state_t;

endpackage

// File: rtl/ACX_SYNCHRONIZER.sv
// Two-flop synchroniser cell for a single asynchronous bit.
// Output clears to 0 while rstn is low.
module ACX_SYNCHRONIZER (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/reset_seq_sync_bus.sv
// Per-bit synchroniser array for the asynchronous sequencer inputs.
// Each bit is independent; no cross-bit coherency is implied.
module reset_seq_sync_bus #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_sync
        ACX_SYNCHRONIZER u_sync (
            .clk  (i_clk),
            .rstn (i_rstn),
            .din  (din[g]),
            .dout (dout[g])
        );
    end

endmodule

// File: rtl/reset_request_sequencer.sv
// Master reset request: hold, wait for stable lock, release,
// then watch every domain leave reset and re-issue on faults.
module reset_request_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS        = 2,
    parameter int ASSERT_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES = 8,
    parameter int RELEASE_TIMEOUT    = 256,
    parameter int CNT_W              = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_pll_lock,
    input  logic [NUM_DOMAINS-1:0] i_domain_rstn,
    input  logic                   i_sw_rst_req,
    input  logic                   i_clr_timeout,
    output logic                   o_rstn,
    output logic                   o_ready,
    output logic                   o_timeout,
    output logic [CNT_W-1:0]       o_reset_count,
    output logic [SEQ_STATE_W-1:0] o_state
);

    localparam int AW = $clog2(ASSERT_CYCLES);
    localparam int LW = (LOCK_STABLE_CYCLES > 1) ?
                        $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int TW = $clog2(RELEASE_TIMEOUT);

    localparam logic [AW-1:0] A_LAST = AW'(ASSERT_CYCLES - 1);
    localparam logic [LW-1:0] L_LAST = LW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(RELEASE_TIMEOUT - 1);

    logic                   lock_s;
    logic [NUM_DOMAINS-1:0] done_s;

    reset_seq_sync_bus #(
        .WIDTH (NUM_DOMAINS + 1)
    ) u_sync (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .din    ({i_domain_rstn, i_pll_lock}),
        .dout   ({done_s, lock_s})
    );

    seq_state_t      state;
    logic [AW-1:0]   a_cnt;
    logic [LW-1:0]   l_cnt;
    logic [TW-1:0]   t_cnt;
    logic            done_all;
    logic            run_exit;
    logic [CNT_W-1:0] count_inc;

    assign done_all = &done_s;
    assign run_exit = i_sw_rst_req | ~lock_s | ~done_all;
    assign o_state  = state;

    // Saturating: the count never wraps back to zero.
    assign count_inc = (o_reset_count == {CNT_W{1'b1}}) ?
                       o_reset_count : o_reset_count + 1'b1;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state         <= ST_ASSERT;
            a_cnt         <= '0;
            l_cnt         <= '0;
            t_cnt         <= '0;
            o_rstn        <= 1'b0;
            o_ready       <= 1'b0;
            o_timeout     <= 1'b0;
            o_reset_count <= '0;
        end else begin
            // A timeout set later in this block overrides the clear.
            if (i_clr_timeout) begin
                o_timeout <= 1'b0;
            end
            unique case (state)
                ST_ASSERT: begin
                    o_rstn  <= 1'b0;
                    o_ready <= 1'b0;
                    if (i_sw_rst_req) begin
                        a_cnt <= '0;
                    end else if (a_cnt == A_LAST) begin
                        state <= ST_WAIT_LOCK;
                        a_cnt <= '0;
                        l_cnt <= '0;
                    end else begin
                        a_cnt <= a_cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (!lock_s) begin
                        l_cnt <= '0;
                    end else if (l_cnt == L_LAST) begin
                        state  <= ST_RELEASE;
                        o_rstn <= 1'b1;
                        l_cnt  <= '0;
                        t_cnt  <= '0;
                    end else begin
                        l_cnt <= l_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (done_all) begin
                        state <= ST_RUN;
                        t_cnt <= '0;
                    end else if (!lock_s) begin
                        state         <= ST_ASSERT;
                        o_rstn        <= 1'b0;
                        o_reset_count <= count_inc;
                        a_cnt         <= '0;
                        t_cnt         <= '0;
                    end else if (t_cnt == T_LAST) begin
                        state         <= ST_ASSERT;
                        o_rstn        <= 1'b0;
                        o_timeout     <= 1'b1;
                        o_reset_count <= count_inc;
                        a_cnt         <= '0;
                        t_cnt         <= '0;
                    end else begin
                        t_cnt <= t_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (run_exit) begin
                        state         <= ST_ASSERT;
                        o_rstn        <= 1'b0;
                        o_ready       <= 1'b0;
                        o_reset_count <= count_inc;
                        a_cnt         <= '0;
                    end else begin
                        o_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_ASSERT;
                    o_rstn  <= 1'b0;
                    o_ready <= 1'b0;
                    a_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_request_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes,
// a negedge monitor pops one per observed change and checks it.
module tb_reset_request_sequencer;

    logic       clk;
    logic       i_rstn;
    logic       i_pll_lock;
    logic [1:0] i_domain_rstn;
    logic       i_sw_rst_req;
    logic       i_clr_timeout;
    logic       o_rstn;
    logic       o_ready;
    logic       o_timeout;
    logic [7:0] o_reset_count;
    logic [2:0] o_state;

    reset_request_sequencer #(
        .NUM_DOMAINS        (2),
        .ASSERT_CYCLES      (16),
        .LOCK_STABLE_CYCLES (8),
        .RELEASE_TIMEOUT    (256),
        .CNT_W              (8)
    ) dut (
        .i_clk         (clk),
        .i_rstn        (i_rstn),
        .i_pll_lock    (i_pll_lock),
        .i_domain_rstn (i_domain_rstn),
        .i_sw_rst_req  (i_sw_rst_req),
        .i_clr_timeout (i_clr_timeout),
        .o_rstn        (o_rstn),
        .o_ready       (o_ready),
        .o_timeout     (o_timeout),
        .o_reset_count (o_reset_count),
        .o_state       (o_state)
    );

    typedef struct {
        logic [13:0] v;
        int          dly;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last  = 0;
    bit started = 0;
    logic [13:0] prev;
    logic [13:0] cur;
    logic [7:0]  c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic ex(input logic [2:0] s, input logic r,
                      input logic y, input logic t,
                      input logic [7:0] n, input int d);
        exp_t e;
        e.v   = {s, r, y, t, n};
        e.dly = d;
        q.push_back(e);
    endtask

    task automatic ex_cycle(input logic t, input logic [7:0] n);
        ex(3'd1, 1'b0, 1'b0, t, n, 16);
        ex(3'd2, 1'b1, 1'b0, t, n, 8);
        ex(3'd3, 1'b1, 1'b0, t, n, 1);
        ex(3'd3, 1'b1, 1'b1, t, n, 1);
    endtask

    task automatic wait_st(input logic [2:0] s, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_state !== s && n < budget);
        if (o_state !== s) begin
            total++;
            bad++;
            $display("FAIL wait_state got=%0d want=%0d", o_state, s);
        end
    endtask

    task automatic wait_rdy(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (o_ready !== 1'b1 && n < budget);
        if (o_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL wait_ready got=%b want=1", o_ready);
        end
    endtask

    task automatic pulse_sw();
        i_sw_rst_req = 1'b1;
        @(negedge clk);
        i_sw_rst_req = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        cur = {o_state, o_rstn, o_ready, o_timeout, o_reset_count};
        if (!started) begin
            prev    = cur;
            started = 1'b1;
            last    = cyc;
        end else if (cur !== prev) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_change got=%h want=none", cur);
            end else begin
                e = q.pop_front();
                chk("outputs", 32'(cur), 32'(e.v));
                if (e.dly >= 0)
                    chk("cycles", 32'(cyc - last), 32'(e.dly));
            end
            prev = cur;
            last = cyc;
        end
        if (!i_rstn) last = cyc;
    end

    initial begin
        i_rstn        = 1'b0;
        i_pll_lock    = 1'b1;
        i_domain_rstn = 2'b11;
        i_sw_rst_req  = 1'b0;
        i_clr_timeout = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rstn", 32'(o_rstn), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        chk("rst_count", 32'(o_reset_count), 32'd0);
        chk("rst_state", 32'(o_state), 32'd0);

        // power-up sequence
        ex_cycle(1'b0, 8'd0);
        @(negedge clk);
        #1 i_rstn = 1'b1;
        wait_rdy(100);

        // lock glitch in WAIT_LOCK restarts the stable count
        ex(3'd0, 1'b0, 1'b0, 1'b0, 8'd1, -1);
        ex(3'd1, 1'b0, 1'b0, 1'b0, 8'd1, 16);
        ex(3'd2, 1'b1, 1'b0, 1'b0, 8'd1, 16);
        ex(3'd3, 1'b1, 1'b0, 1'b0, 8'd1, 1);
        ex(3'd3, 1'b1, 1'b1, 1'b0, 8'd1, 1);
        pulse_sw();
        wait_st(3'd1, 100);
        repeat (5) @(negedge clk);
        i_pll_lock = 1'b0;
        @(negedge clk);
        i_pll_lock = 1'b1;
        wait_rdy(100);

        // release timeout with one domain stuck, then recovery
        ex(3'd0, 1'b0, 1'b0, 1'b0, 8'd2, -1);
        ex(3'd1, 1'b0, 1'b0, 1'b0, 8'd2, 16);
        ex(3'd2, 1'b1, 1'b0, 1'b0, 8'd2, 8);
        ex(3'd0, 1'b0, 1'b0, 1'b1, 8'd3, 256);
        ex_cycle(1'b1, 8'd3);
        ex(3'd3, 1'b1, 1'b1, 1'b0, 8'd3, -1);
        i_domain_rstn = 2'b01;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (o_timeout !== 1'b1 && n < 800);
            if (o_timeout !== 1'b1) begin
                total++;
                bad++;
                $display("FAIL wait_timeout got=%b want=1", o_timeout);
            end
        end
        i_domain_rstn = 2'b11;
        wait_rdy(100);
        i_clr_timeout = 1'b1;
        @(negedge clk);
        i_clr_timeout = 1'b0;
        repeat (3) @(negedge clk);

        // sw request coincident with lock loss counts once
        ex(3'd0, 1'b0, 1'b0, 1'b0, 8'd4, -1);
        ex_cycle(1'b0, 8'd4);
        i_pll_lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_sw_rst_req = 1'b1;
        @(negedge clk);
        i_sw_rst_req = 1'b0;
        i_pll_lock   = 1'b1;
        wait_rdy(100);

        // saturation of the re-issue counter
        c = 8'd4;
        for (int i = 0; i < 300; i++) begin
            c = (c == 8'hff) ? c : c + 8'd1;
            ex(3'd0, 1'b0, 1'b0, 1'b0, c, -1);
            ex_cycle(1'b0, c);
            pulse_sw();
            wait_rdy(100);
        end

        // async reset during RELEASE
        ex(3'd0, 1'b0, 1'b0, 1'b0, 8'hff, -1);
        ex(3'd1, 1'b0, 1'b0, 1'b0, 8'hff, 16);
        ex(3'd2, 1'b1, 1'b0, 1'b0, 8'hff, 8);
        ex(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, -1);
        ex_cycle(1'b0, 8'd0);
        i_domain_rstn = 2'b00;
        wait_st(3'd2, 100);
        repeat (3) @(negedge clk);
        #2 i_rstn = 1'b0;
        #1;
        chk("async_rstn", 32'(o_rstn), 32'd0);
        chk("async_ready", 32'(o_ready), 32'd0);
        chk("async_count", 32'(o_reset_count), 32'd0);
        chk("async_state", 32'(o_state), 32'd0);
        repeat (3) @(negedge clk);
        i_domain_rstn = 2'b11;
        @(negedge clk);
        #1 i_rstn = 1'b1;
        wait_rdy(100);
        repeat (4) @(negedge clk);
        chk("queue_left", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
